// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time and answers after LATENCY cycles.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHK_EN.
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_wr,
    output logic              rsp_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [ADDR_W-1:0] req_idx;
    logic              misalign;
    logic              accept;
    logic              mem_we;
    logic              unused_addr_bits;

    assign req_idx = req_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

`ifdef DMEM_ALIGN_CHK_EN
    assign misalign = |req_addr[1:0];
`else
    assign misalign = 1'b0;
`endif

    assign accept = (state_q == S_IDLE) && req_valid;
    // A misaligned store is dropped so the array never sees a partial-word write.
    assign mem_we = accept && req_wr && !misalign;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    idx_d = req_idx;
                    wr_d  = req_wr;
                    err_d = misalign;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                        rdata_d = (req_wr || misalign) ? '0 : mem_q[req_idx];
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                    // Load data is sampled on entry to RESP, after any same-address store committed.
                    rdata_d = (wr_q || err_q) ? '0 : mem_q[idx_q];
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage has no reset so accepted stores survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[req_idx] <= req_wdata;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_wr    = wr_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance for the main traffic
// and a LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_wr, rsp_valid, rsp_ready, rsp_wr, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;

    logic        l1_req_valid, l1_req_ready, l1_req_wr, l1_rsp_valid, l1_rsp_ready, l1_rsp_wr, l1_rsp_err;
    logic [31:0] l1_req_addr, l1_req_wdata, l1_rsp_rdata;

    dmem_responder #(.ADDR_W(10), .DATA_W(32), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_wr(rsp_wr), .rsp_err(rsp_err)
    );

    dmem_responder #(.ADDR_W(10), .DATA_W(32), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_wr(l1_req_wr),
        .req_addr(l1_req_addr), .req_wdata(l1_req_wdata),
        .rsp_valid(l1_rsp_valid), .rsp_ready(l1_rsp_ready), .rsp_rdata(l1_rsp_rdata),
        .rsp_wr(l1_rsp_wr), .rsp_err(l1_rsp_err)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        wr;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        sb1[$];
    logic [31:0] mdl  [1024];
    logic [31:0] mdl1 [1024];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic predict(input logic wr, input logic [31:0] addr, input logic [31:0] wd, output exp_t e);
        logic mis;
`ifdef DMEM_ALIGN_CHK_EN
        mis = |addr[1:0];
`else
        mis = 1'b0;
`endif
        if (wr && !mis) mdl[addr[11:2]] = wd;
        e.rdata = (wr || mis) ? 32'h0 : mdl[addr[11:2]];
        e.wr    = wr;
        e.err   = mis;
    endtask

    task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input int hold);
        exp_t e;
        int   n;
        @(negedge clk);
        check("idle_rdy", req_ready, 1);
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd;
        predict(wr, addr, wd, e);
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0; req_wr = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            check("busy_rdy", req_ready, 0);
            @(negedge clk);
            n++;
        end
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        if (!rsp_valid) begin
            check("rsp_timeout", 0, 1);
            return;
        end
        check("latency", n, LAT);
        check("rdata", rsp_rdata, e.rdata);
        check("rsp_wr", rsp_wr, e.wr);
        check("rsp_err", rsp_err, e.err);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_vld", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, e.rdata);
            check("hold_wr", rsp_wr, e.wr);
            check("hold_rdy", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("done_vld", rsp_valid, 0);
        check("done_rdata", rsp_rdata, 0);
        check("done_rdy", req_ready, 1);
        check("done_err", rsp_err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        exp_t        e;
        logic [31:0] l1_addr [8];
        logic [31:0] l1_data [8];
        int          k, last, cyc;

        rst = 1'b0;
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h10; req_wdata = 32'h5555_5555; rsp_ready = 1'b0;
        l1_req_valid = 1'b0; l1_req_wr = 1'b0; l1_req_addr = 32'h0; l1_req_wdata = 32'h0; l1_rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdy", req_ready, 1);
        check("rst_vld", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_wr", rsp_wr, 0);
        check("rst_err", rsp_err, 0);
        rst = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        @(negedge clk);
        check("rel_rdy", req_ready, 1);
        check("rel_vld", rsp_valid, 0);
        check("rel_rdata", rsp_rdata, 0);

        xact(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
        xact(1'b0, 32'h0000_0010, 32'h0, 0);
        xact(1'b0, 32'h0000_0010, 32'h0, 5);
        xact(1'b1, 32'h0000_1004, 32'h1234_5678, 0);
        xact(1'b0, 32'h0000_0004, 32'h0, 0);
        xact(1'b1, 32'h0000_0013, 32'hFFFF_FFFF, 0);
        xact(1'b0, 32'h0000_0010, 32'h0, 0);

        for (int i = 0; i < 6; i++) begin
            a = $urandom & 32'hFFFF_FFFC;
            d = $urandom;
            xact(1'b1, a, d, i % 3);
            xact(1'b0, a, 32'h0, 0);
        end

        // Reset while a store is in flight: the store stays committed, no response.
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFE_F00D;
        mdl[16] = 32'hCAFE_F00D;
        @(negedge clk);
        req_valid = 1'b0; req_wr = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        rst = 1'b0;
        #1;
        check("mid_rst_rdy", req_ready, 1);
        check("mid_rst_vld", rsp_valid, 0);
        check("mid_rst_rdata", rsp_rdata, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("mid_rst_novld", rsp_valid, 0);
        end

        // Reset while a load response is pending: it is discarded.
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h10;
        @(negedge clk);
        req_valid = 1'b0; req_addr = 32'h0;
        @(negedge clk);
        check("pre_rst_vld", rsp_valid, 1);
        rst = 1'b0;
        #1;
        check("ld_rst_vld", rsp_valid, 0);
        check("ld_rst_rdata", rsp_rdata, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("ld_rst_novld", rsp_valid, 0);
        end
        xact(1'b0, 32'h0000_0040, 32'h0, 0);

        // LATENCY=1 instance: request held valid, response consumed every cycle.
        for (int i = 0; i < 4; i++) begin
            l1_addr[i]     = 32'h20 + 32'(i * 4);
            l1_data[i]     = $urandom;
            l1_addr[i + 4] = l1_addr[i];
            l1_data[i + 4] = 32'h0;
        end
        l1_rsp_ready = 1'b1;
        k = 0; last = -1; cyc = 0;
        while ((k < 8 || sb1.size() != 0) && cyc < 60) begin
            @(negedge clk);
            if (l1_rsp_valid) begin
                if (sb1.size() == 0) begin
                    check("l1_spurious", 1, 0);
                end else begin
                    e = sb1.pop_front();
                    check("l1_lat", cyc - last, 1);
                    check("l1_rdata", l1_rsp_rdata, e.rdata);
                    check("l1_wr", l1_rsp_wr, e.wr);
                    check("l1_err", l1_rsp_err, e.err);
                end
            end
            check("l1_alt", l1_rsp_valid, !l1_req_ready);
            if (l1_req_ready) begin
                if (k < 8) begin
                    if (last >= 0) check("l1_gap", cyc - last, 2);
                    l1_req_valid = 1'b1;
                    l1_req_wr    = (k < 4);
                    l1_req_addr  = l1_addr[k];
                    l1_req_wdata = l1_data[k];
                    if (k < 4) mdl1[l1_addr[k][11:2]] = l1_data[k];
                    e.rdata = (k < 4) ? 32'h0 : mdl1[l1_addr[k][11:2]];
                    e.wr    = (k < 4);
                    e.err   = 1'b0;
                    sb1.push_back(e);
                    last = cyc;
                    k++;
                end else begin
                    l1_req_valid = 1'b0;
                end
            end
            cyc++;
        end
        l1_req_valid = 1'b0;
        check("l1_drain", sb1.size(), 0);
        check("l1_count", k, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder, i.e. the slave end of the load/store request interface that the MEM stage drives.
- Accepts one request at a time from the MEM stage: address, write data and a write flag.
- Holds a word-addressed storage array and returns read data or a write acknowledge after a fixed, parameterised latency.
- The MEM stage stalls the pipeline while a request is outstanding.

Parameters:
- ADDR_W, 10, word-address bits; array depth = 2**ADDR_W words of DATA_W bits.
- DATA_W, 32, data word width.
- LATENCY, 2, cycles from request accept to rsp_valid; legal range >= 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_wr  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address; word index = req_addr[ADDR_W+1:2].
- req_wdata  input  DATA_W  store data.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  requester consumes the response.
- rsp_rdata  output  DATA_W  load data; 0 for store acks.
- rsp_wr  output  1  echoes req_wr of the request being answered.
- rsp_err  output  1  error flag; tied 0 unless DMEM_ALIGN_CHK_EN is defined.

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_wr=0, rsp_err=0, latency counter=0.
  - The storage array is NOT reset; its contents are unchanged.
- FSM states:
  - IDLE: req_ready=1. On req_valid at the edge (accept):
    - capture the word index and req_wr;
    - for a store, write req_wdata to the array at that same edge;
    - if LATENCY==1 go to RESP, else go to BUSY with counter=LATENCY-1.
  - BUSY: req_ready=0. Counter decrements each cycle. When the counter reaches 1, go to RESP at the next edge.
  - RESP:
    - rsp_valid=1, req_ready=0.
    - Load: rsp_rdata = array word at the captured index, sampled on entry to RESP.
    - Store: rsp_rdata = 0.
    - rsp_wr and rsp_err are held stable.
    - When rsp_ready=1 at the edge, return to IDLE; rsp_valid and rsp_rdata clear to 0.
- Latency: a request accepted at edge N gives rsp_valid=1 in the cycle after edge N+LATENCY-1. The response is held indefinitely until rsp_ready.
- Throughput: at most one outstanding request. No new request is accepted in the cycle where the response is consumed; the earliest next accept is the following edge.
- Address handling:
  - req_addr bits above ADDR_W+1 are ignored, so addresses wrap modulo the array size.
  - Bits [1:0] are ignored when the check macro is off.
- Load after store to the same address returns the stored value, because the store commits on its accept edge.
- Reset mid-operation:
  - A store that has already been accepted stays committed.
  - A pending load or ack is discarded; no rsp_valid follows.
- Outside IDLE, req_valid and the other request fields are don't-care.
- rsp_ready is ignored outside RESP.

Optional Feature:
- Macro: DMEM_ALIGN_CHK_EN.
- Defined:
  - On accept, if req_addr[1:0]!=0, the store is suppressed and the array is unchanged.
  - The response carries rsp_err=1, rsp_rdata=0, with normal latency.
  - rsp_err clears when the response is consumed.
- Undefined: rsp_err is constant 0 and the low address bits are ignored.

Test Plan:
- Reset: rst=0 during traffic, then release -> req_ready=1, rsp_valid=0, rsp_rdata=0 immediately and after release.
- Store then load, LATENCY=2:
  - store addr 0x0000_0010, data 0xDEAD_BEEF -> rsp_valid exactly 2 cycles after accept, rsp_wr=1, rsp_rdata=0;
  - then load 0x10 -> rsp_rdata=0xDEAD_BEEF, rsp_wr=0.
- Backpressure: hold rsp_ready=0 for 5 cycles on a load response -> rsp_valid and rsp_rdata stable, req_ready=0 throughout. Raise rsp_ready -> IDLE next cycle.
- Wrap, ADDR_W=10:
  - store 0x1234_5678 at byte addr 0x0000_1004;
  - load addr 0x0000_0004 -> returns 0x1234_5678.
- LATENCY=1: back-to-back loads with rsp_ready tied 1 -> rsp_valid one cycle after each accept, one request accepted every 2 cycles.
- Misaligned store with DMEM_ALIGN_CHK_EN defined:
  - store 0xFFFF_FFFF at addr 0x13 -> rsp_err=1;
  - load 0x10 still returns the prior value.
- Without DMEM_ALIGN_CHK_EN: the same misaligned store writes word 4 and rsp_err=0.
